// File: rtl/dcls_pkg.sv
// dcls_pkg: shared types and constants for the lockstep comparator controller.
package dcls_pkg;

  // Controller states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FAULT  = 2'd3
  } dcls_state_e;

  // Core1 delay-line selection (0..3 cycles).
  typedef logic [1:0] dcls_delay_t;

  localparam int DCLS_MAX_DELAY = 3;

  // Number of cycles the comparator stays masked while the pipeline refills.
  function automatic int warmup_len(input int base, input dcls_delay_t dly);
    return base + int'(dly);
  endfunction

endpackage

// File: rtl/dcls_warmup_timer.sv
// dcls_warmup_timer: loadable down-counter. A load of N makes done_o rise on
// the N-th running cycle after the load edge.
module dcls_warmup_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         run_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load N-1 so the zero-count cycle is the last masked cycle; a zero load behaves like one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= (load_val_i == '0) ? '0 : load_val_i - W'(1);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dcls_lockstep_ctrl.sv
// dcls_lockstep_ctrl: run-time controller for the dual-core lockstep comparator.
// Owns delay_sel, masks the comparator during pipeline refill, qualifies and
// counts mismatches and escalates persistent ones to a sticky fault.
// Define DCLS_CTRL_SELFTEST_EN to build the error-injection self-test path.
module dcls_lockstep_ctrl
  import dcls_pkg::*;
#(
  parameter int NUM_SIGNALS   = 8,
  parameter int WARMUP_CYCLES = 4,
  parameter int ERR_THRESH    = 2,
  parameter int CNT_W         = 16
`ifdef DCLS_CTRL_SELFTEST_EN
  ,
  parameter int INJ_WINDOW    = 4
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   cfg_valid,
  input  logic [1:0]             cfg_delay,
  output logic                   cfg_ready,
  output logic [1:0]             delay_sel,
  input  logic                   cmp_error,
  input  logic [NUM_SIGNALS-1:0] cmp_vector,
  input  logic                   fault_clear,
  output logic                   cmp_active,
  output logic                   fault,
  output logic [NUM_SIGNALS-1:0] fault_vector,
  output logic [CNT_W-1:0]       mismatch_cnt,
`ifdef DCLS_CTRL_SELFTEST_EN
  input  logic                   inject_req,
  output logic                   inject,
  output logic                   selftest_pass,
  output logic                   selftest_fail,
`endif
  output logic [1:0]             state_o
);

  localparam int TMR_W = $clog2(WARMUP_CYCLES + DCLS_MAX_DELAY + 1);

  dcls_state_e            state_q, state_d;
  dcls_delay_t            delay_q, delay_d;
  logic                   cfg_ready_q, cmp_active_q;
  logic                   fault_q, fault_d;
  logic [NUM_SIGNALS-1:0] fv_q, fv_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             consec_q, consec_d;
  logic                   xfer, hit, busy_d;
  logic                   tmr_load, tmr_done;
  logic [TMR_W-1:0]       tmr_len;

`ifdef DCLS_CTRL_SELFTEST_EN
  localparam int WIN_W = $clog2(INJ_WINDOW + 1);
  logic             st_q, st_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             inject_q, inject_d, pass_q, pass_d, fail_q, fail_d;
  assign busy_d = st_d;
`else
  assign busy_d = 1'b0;
`endif

  assign xfer    = cfg_valid && cfg_ready_q;
  // This mismatch completes a run of ERR_THRESH consecutive qualified mismatches.
  assign hit     = cmp_error && (({1'b0, consec_q} + 9'd1) >= 9'(ERR_THRESH));
  // Warmup length always uses the delay in effect after this edge.
  assign tmr_len = TMR_W'(warmup_len(WARMUP_CYCLES, delay_d));

  dcls_warmup_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_len),
    .run_i      (state_q == ST_WARMUP),
    .done_o     (tmr_done)
  );

  // Next-state and bookkeeping decisions; fault beats en-drop beats reconfiguration.
  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    fault_d  = fault_q;
    fv_d     = fv_q;
    cnt_d    = cnt_q;
    consec_d = consec_q;
    tmr_load = 1'b0;
`ifdef DCLS_CTRL_SELFTEST_EN
    st_d     = st_q;
    win_d    = win_q;
    inject_d = 1'b0;
    pass_d   = 1'b0;
    fail_d   = 1'b0;
`endif
    if (xfer) begin
      delay_d = cfg_delay;
    end
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d  = ST_WARMUP;
          tmr_load = 1'b1;
        end
      end
      ST_WARMUP: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
`ifdef DCLS_CTRL_SELFTEST_EN
        if (st_q) begin
          // Self-test window: an injected error must show up on the comparator.
          if (!en) begin
            state_d = ST_IDLE;
            st_d    = 1'b0;
          end else if (cmp_error) begin
            pass_d   = 1'b1;
            st_d     = 1'b0;
            state_d  = ST_WARMUP;
            tmr_load = 1'b1;
          end else if (win_q == WIN_W'(1)) begin
            fail_d  = 1'b1;
            st_d    = 1'b0;
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            win_d = win_q - WIN_W'(1);
          end
        end else
`endif
        begin
          if (cmp_error) begin
            consec_d = consec_q + 8'd1;
            cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
            fv_d     = fv_q | cmp_vector;
          end else begin
            consec_d = '0;
          end
          if (hit) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else if (!en) begin
            state_d = ST_IDLE;
          end else if (xfer) begin
            state_d  = ST_WARMUP;
            tmr_load = 1'b1;
          end
`ifdef DCLS_CTRL_SELFTEST_EN
          else if (inject_req) begin
            st_d     = 1'b1;
            win_d    = WIN_W'(INJ_WINDOW);
            inject_d = 1'b1;
          end
`endif
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          state_d  = ST_WARMUP;
          tmr_load = 1'b1;
          fault_d  = 1'b0;
          fv_d     = '0;
          cnt_d    = '0;
          consec_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A refill starts a fresh mismatch run.
    if ((state_d == ST_IDLE) || (state_d == ST_WARMUP)) begin
      consec_d = '0;
    end
  end

  // State and registered outputs; handshake/qualify flags follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      delay_q      <= '0;
      cfg_ready_q  <= 1'b0;
      cmp_active_q <= 1'b0;
      fault_q      <= 1'b0;
      fv_q         <= '0;
      cnt_q        <= '0;
      consec_q     <= '0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      cfg_ready_q  <= (state_d != ST_WARMUP) && !busy_d;
      cmp_active_q <= (state_d == ST_ACTIVE) && !busy_d;
      fault_q      <= fault_d;
      fv_q         <= fv_d;
      cnt_q        <= cnt_d;
      consec_q     <= consec_d;
    end
  end

`ifdef DCLS_CTRL_SELFTEST_EN
  // Self-test sub-state, window counter and one-cycle result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= 1'b0;
      win_q    <= '0;
      inject_q <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      win_q    <= win_d;
      inject_q <= inject_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  assign inject        = inject_q;
  assign selftest_pass = pass_q;
  assign selftest_fail = fail_q;
`endif

  assign cfg_ready    = cfg_ready_q;
  assign delay_sel    = delay_q;
  assign cmp_active   = cmp_active_q;
  assign fault        = fault_q;
  assign fault_vector = fv_q;
  assign mismatch_cnt = cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_dcls_lockstep_ctrl.sv
// tb_dcls_lockstep_ctrl: directed vector table, async-reset check, randomized
// run against a behavioural model, and a counter-saturation sequence.
module tb_dcls_lockstep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        rst_n, en, cfg_valid, cmp_error, fault_clear;
  logic [1:0]  cfg_delay, delay_sel, state_o;
  logic [7:0]  cmp_vector, fault_vector;
  logic        cfg_ready, cmp_active, fault;
  logic [15:0] mismatch_cnt;

  dcls_lockstep_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_delay    (cfg_delay),
    .cfg_ready    (cfg_ready),
    .delay_sel    (delay_sel),
    .cmp_error    (cmp_error),
    .cmp_vector   (cmp_vector),
    .fault_clear  (fault_clear),
    .cmp_active   (cmp_active),
    .fault        (fault),
    .fault_vector (fault_vector),
    .mismatch_cnt (mismatch_cnt),
    .state_o      (state_o)
  );

  // Narrow-counter instance for the saturation sequence
  logic       s_rst_n, s_en, s_cfg_valid, s_cmp_error, s_fault_clear;
  logic [1:0] s_cfg_delay, s_delay_sel, s_state;
  logic [7:0] s_cmp_vector, s_fv;
  logic       s_cfg_ready, s_cmp_active, s_fault;
  logic [3:0] s_cnt;

  dcls_lockstep_ctrl #(
    .CNT_W      (4),
    .ERR_THRESH (2)
  ) u_sat (
    .clk          (clk),
    .rst_n        (s_rst_n),
    .en           (s_en),
    .cfg_valid    (s_cfg_valid),
    .cfg_delay    (s_cfg_delay),
    .cfg_ready    (s_cfg_ready),
    .delay_sel    (s_delay_sel),
    .cmp_error    (s_cmp_error),
    .cmp_vector   (s_cmp_vector),
    .fault_clear  (s_fault_clear),
    .cmp_active   (s_cmp_active),
    .fault        (s_fault),
    .fault_vector (s_fv),
    .mismatch_cnt (s_cnt),
    .state_o      (s_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input int st, input logic rdy, input logic act,
                            input logic [1:0] dly, input logic flt, input logic [7:0] fv,
                            input int cnt);
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'(rdy));
    chk({tag, "_cmp_active"}, 32'(cmp_active), 32'(act));
    chk({tag, "_delay_sel"}, 32'(delay_sel), 32'(dly));
    chk({tag, "_fault"}, 32'(fault), 32'(flt));
    chk({tag, "_fault_vector"}, 32'(fault_vector), 32'(fv));
    chk({tag, "_mismatch_cnt"}, 32'(mismatch_cnt), 32'(cnt));
  endtask

  // Directed vectors: inputs applied for one cycle, outputs expected after that edge
  typedef struct {
    logic       en, cv;
    logic [1:0] cd;
    logic       ce;
    logic [7:0] vec;
    logic       fc;
    int         st;
    logic       rdy, act;
    logic [1:0] dly;
    logic       flt;
    logic [7:0] fv;
    int         cnt;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic en_v, input logic cv_v, input logic [1:0] cd_v, input logic ce_v,
                     input logic [7:0] vec_v, input logic fc_v, input int st_v, input logic rdy_v,
                     input logic act_v, input logic [1:0] dly_v, input logic flt_v,
                     input logic [7:0] fv_v, input int cnt_v);
    row_t r;
    r.en = en_v; r.cv = cv_v; r.cd = cd_v; r.ce = ce_v; r.vec = vec_v; r.fc = fc_v;
    r.st = st_v; r.rdy = rdy_v; r.act = act_v; r.dly = dly_v; r.flt = flt_v;
    r.fv = fv_v; r.cnt = cnt_v;
    tbl.push_back(r);
  endtask

  // Behavioural model: remembers when warmup began and how long it lasts
  localparam int CMAX = 65535;
  int         m_st, m_step, m_enter, m_len, m_run, m_cnt;
  logic [7:0] m_fv;
  logic [1:0] m_dly;
  logic       m_flt, m_rdy;

  task automatic model_reset();
    m_st = 0; m_step = 0; m_enter = 0; m_len = 0; m_run = 0; m_cnt = 0;
    m_fv = '0; m_dly = '0; m_flt = 1'b0; m_rdy = 1'b0;
  endtask

  task automatic start_warmup(input int dly);
    m_st = 1; m_enter = m_step; m_len = 4 + dly; m_run = 0;
  endtask

  task automatic model_step();
    bit xfer;
    int nd;
    m_step++;
    xfer = cfg_valid && m_rdy;
    nd   = xfer ? int'(cfg_delay) : int'(m_dly);
    if (m_st == 0) begin
      if (en) start_warmup(nd);
    end else if (m_st == 1) begin
      if (!en) m_st = 0;
      else if (m_step - m_enter == m_len) m_st = 2;
    end else if (m_st == 2) begin
      if (cmp_error) begin
        m_run++;
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        m_fv  = m_fv | cmp_vector;
      end else begin
        m_run = 0;
      end
      if (m_run >= 2) begin
        m_st = 3; m_flt = 1'b1;
      end else if (!en) begin
        m_st = 0; m_run = 0;
      end else if (xfer) begin
        start_warmup(nd);
      end
    end else begin
      if (fault_clear) begin
        start_warmup(nd);
        m_flt = 1'b0; m_fv = '0; m_cnt = 0;
      end
    end
    m_dly = 2'(nd);
    m_rdy = (m_st != 1);
  endtask

  initial begin
    rst_n = 1'b0; en = 0; cfg_valid = 0; cfg_delay = 0; cmp_error = 0; cmp_vector = 0;
    fault_clear = 0;
    s_rst_n = 1'b0; s_en = 0; s_cfg_valid = 0; s_cfg_delay = 0; s_cmp_error = 0;
    s_cmp_vector = 8'h01; s_fault_clear = 0;

    // en, cv, cd, ce, vec, fc  ->  st, rdy, act, dly, flt, fv, cnt
    add(0,0,0,0,8'h00,0, 0,1,0,0,0,8'h00,0);
    add(1,0,0,0,8'h00,0, 1,0,0,0,0,8'h00,0);
    add(1,0,0,1,8'hFF,0, 1,0,0,0,0,8'h00,0);
    add(1,0,0,0,8'h00,0, 1,0,0,0,0,8'h00,0);
    add(1,0,0,0,8'h00,0, 1,0,0,0,0,8'h00,0);
    add(1,0,0,0,8'h00,0, 2,1,1,0,0,8'h00,0);
    add(1,0,0,1,8'h04,0, 2,1,1,0,0,8'h04,1);
    add(1,0,0,0,8'h00,0, 2,1,1,0,0,8'h04,1);
    add(1,0,0,1,8'h04,0, 2,1,1,0,0,8'h04,2);
    add(1,0,0,0,8'h00,0, 2,1,1,0,0,8'h04,2);
    add(1,1,3,0,8'h00,0, 1,0,0,3,0,8'h04,2);
    for (int i = 0; i < 6; i++) add(1,0,0,0,8'h00,0, 1,0,0,3,0,8'h04,2);
    add(1,0,0,0,8'h00,0, 2,1,1,3,0,8'h04,2);
    add(1,0,0,1,8'h04,0, 2,1,1,3,0,8'h04,3);
    add(1,0,0,1,8'h10,0, 3,1,0,3,1,8'h14,4);
    add(1,0,0,0,8'h00,0, 3,1,0,3,1,8'h14,4);
    add(0,0,0,0,8'h00,0, 3,1,0,3,1,8'h14,4);
    add(1,1,1,0,8'h00,1, 1,0,0,1,0,8'h00,0);
    for (int i = 0; i < 4; i++) add(1,0,0,0,8'h00,0, 1,0,0,1,0,8'h00,0);
    add(1,0,0,0,8'h00,0, 2,1,1,1,0,8'h00,0);
    add(1,0,0,1,8'h01,0, 2,1,1,1,0,8'h01,1);
    add(1,1,2,1,8'h02,0, 3,1,0,2,1,8'h03,2);
    add(1,0,0,0,8'h00,1, 1,0,0,2,0,8'h00,0);
    add(0,0,0,0,8'h00,0, 0,1,0,2,0,8'h00,0);
    add(0,1,0,0,8'h00,0, 0,1,0,0,0,8'h00,0);
    add(1,0,0,1,8'h80,0, 1,0,0,0,0,8'h00,0);
    for (int i = 0; i < 3; i++) add(1,0,0,0,8'h00,0, 1,0,0,0,0,8'h00,0);
    add(1,0,0,0,8'h00,0, 2,1,1,0,0,8'h00,0);
    add(1,0,0,1,8'h01,0, 2,1,1,0,0,8'h01,1);
    add(0,0,0,1,8'h02,0, 3,1,0,0,1,8'h03,2);

    // Reset values
    repeat (2) @(negedge clk);
    check_main("reset", 0, 0, 0, 2'd0, 0, 8'h00, 0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; cfg_valid = tbl[i].cv; cfg_delay = tbl[i].cd;
      cmp_error = tbl[i].ce; cmp_vector = tbl[i].vec; fault_clear = tbl[i].fc;
      @(negedge clk);
      check_main($sformatf("row%0d", i), tbl[i].st, tbl[i].rdy, tbl[i].act, tbl[i].dly,
                 tbl[i].flt, tbl[i].fv, tbl[i].cnt);
    end

    // Asynchronous reset mid-operation (table leaves the DUT in FAULT)
    rst_n = 1'b0;
    en = 0; cfg_valid = 0; cmp_error = 0; fault_clear = 0;
    #1;
    check_main("async_rst", 0, 0, 0, 2'd0, 0, 8'h00, 0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Randomized run against the model
    for (int c = 0; c < 800; c++) begin
      check_main($sformatf("rnd%0d", c), m_st, m_rdy, (m_st == 2), m_dly, m_flt, m_fv, m_cnt);
      if (!(cfg_valid && !m_rdy)) begin
        cfg_valid = ($urandom_range(0, 7) == 0);
        cfg_delay = 2'($urandom_range(0, 3));
      end
      en          = ($urandom_range(0, 24) != 0);
      cmp_error   = ($urandom_range(0, 4) == 0);
      cmp_vector  = 8'($urandom);
      fault_clear = ($urandom_range(0, 5) == 0);
      model_step();
      @(negedge clk);
    end

    // Saturation: alternating mismatches never reach the threshold, count clamps at 15
    s_rst_n = 1'b1;
    s_en    = 1'b1;
    begin
      int waited = 0;
      while (s_cmp_active !== 1'b1 && waited < 30) begin
        @(negedge clk);
        waited++;
      end
      chk("sat_reach_active", 32'(s_cmp_active), 32'd1);
    end
    for (int i = 0; i < 40; i++) begin
      int exp_cnt;
      s_cmp_error = (i % 2 == 0);
      @(negedge clk);
      exp_cnt = (i / 2 + 1 > 15) ? 15 : i / 2 + 1;
      chk($sformatf("sat%0d_cnt", i), 32'(s_cnt), 32'(exp_cnt));
      chk($sformatf("sat%0d_fault", i), 32'(s_fault), 32'd0);
    end
    chk("sat_state", 32'(s_state), 32'd2);
    chk("sat_cfg_ready", 32'(s_cfg_ready), 32'd1);
    chk("sat_delay_sel", 32'(s_delay_sel), 32'd0);
    chk("sat_fault_vector", 32'(s_fv), 32'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcls_lockstep_ctrl.md
Name: dcls_lockstep_ctrl

Overview:
- Run-time controller for the dual-core lockstep comparator path.
- Owns the core1 delay selection and accepts reconfiguration through a valid/ready handshake.
- Masks the comparator while the input/delay/core pipeline refills, then qualifies mismatches and escalates persistent ones to a sticky fault.
- Sits beside the lockstep top-level: drives its delay_sel and consumes its error/error_vector.

Parameters:
- NUM_SIGNALS, 8, width of comparator mismatch vector
- WARMUP_CYCLES, 4, base pipeline-fill mask length; actual mask = WARMUP_CYCLES + delay_sel
- ERR_THRESH, 2, consecutive qualified mismatch cycles that declare a fault (legal range 1..255)
- CNT_W, 16, width of saturating mismatch counter

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- en  in  1  lockstep checking enable
- cfg_valid  in  1  new delay request
- cfg_delay  in  2  requested delay (0..3 cycles)
- cfg_ready  out  1  controller can accept cfg
- delay_sel  out  2  registered delay to delay line
- cmp_error  in  1  raw comparator any-mismatch
- cmp_vector  in  NUM_SIGNALS  raw per-signal mismatch
- fault_clear  in  1  software clear of fault
- cmp_active  out  1  comparator result is qualified this cycle
- fault  out  1  sticky lockstep fault
- fault_vector  out  NUM_SIGNALS  sticky OR of qualified cmp_vector
- mismatch_cnt  out  CNT_W  saturating count of qualified mismatch cycles
- state_o  out  2  current FSM state encoding

Behaviour:
- Reset values:
  - state IDLE; delay_sel 0; cfg_ready 0; cmp_active 0; fault 0; fault_vector 0; mismatch_cnt 0.
  - Internal consecutive counter and warmup timer cleared.
- States:
  - IDLE=0, WARMUP=1, ACTIVE=2, FAULT=3.
- IDLE:
  - cfg_ready=1.
  - en=1 → WARMUP, timer loaded with WARMUP_CYCLES+delay_sel.
- WARMUP:
  - cfg_ready=0; cmp_active=0; cmp_error ignored.
  - Timer decrements each cycle; at 0 → ACTIVE.
- ACTIVE:
  - cfg_ready=1; cmp_active=1.
  - Qualified mismatch (cmp_error=1):
    - consecutive counter +1;
    - mismatch_cnt +1, saturating at all-ones;
    - fault_vector |= cmp_vector.
  - A clean cycle resets the consecutive counter to 0.
  - Consecutive counter reaching ERR_THRESH → FAULT; fault=1 from the next cycle.
- FAULT:
  - cfg_ready=1; cmp_active=0; fault held.
  - fault_clear → WARMUP (reload timer), clearing fault, fault_vector, mismatch_cnt and the consecutive counter.
- Config handshake:
  - Transfer when cfg_valid && cfg_ready.
  - delay_sel <= cfg_delay on the next edge.
  - From ACTIVE: → WARMUP with timer = WARMUP_CYCLES+cfg_delay.
  - From IDLE/FAULT: state unchanged; delay_sel updated only.
  - cfg_valid while cfg_ready=0 is held off; the requester must keep cfg_valid stable until transfer.
- en deassert: from WARMUP/ACTIVE → IDLE next cycle. FAULT ignores en (sticky).
- Latency: cmp_error to fault = 1 cycle after threshold is met; cfg transfer to delay_sel = 1 cycle.
- Simultaneous events:
  - ACTIVE, threshold reached + cfg transfer: delay_sel updates, state → FAULT (fault wins).
  - FAULT, fault_clear + cfg transfer: delay_sel updates, → WARMUP using the new delay.
  - ACTIVE, en=0 + threshold reached: → FAULT.
- Reset mid-operation: all state returns to reset values asynchronously; a pending cfg is dropped.

Optional Feature:
- Macro DCLS_CTRL_SELFTEST_EN. When defined, adds:
  - ports inject_req (in 1), inject (out 1), selftest_pass (out 1), selftest_fail (out 1);
  - parameter INJ_WINDOW (default 4).
- In ACTIVE, inject_req pulses inject for 1 cycle; the inject pulse corrupts a core1 input bit externally.
- Sub-state SELFTEST lasts INJ_WINDOW cycles:
  - cmp_error in the window → selftest_pass 1-cycle pulse, return to WARMUP; mismatch not counted, fault not raised.
  - no cmp_error by window end → selftest_fail pulse and FAULT (latent comparator fault).
- inject_req outside ACTIVE is ignored.
- Without the macro, none of these ports or logic exist.

Decomposition:
- Shared package dcls_pkg:
  - enum dcls_state_e;
  - typedef dcls_delay_t (logic [1:0]);
  - constant DCLS_MAX_DELAY=3.
- Sub-module dcls_warmup_timer: loadable down-counter with a done flag.

Test Plan:
- Reset then en=1, delay_sel=0: cmp_active rises after exactly 4 cycles in WARMUP; cmp_error pulsed during WARMUP is not counted.
- ACTIVE, cfg_delay=3 transfer: delay_sel=3 next cycle, cfg_ready=0 for 7 WARMUP cycles, then ACTIVE.
- ACTIVE, single-cycle cmp_error with cmp_vector=8'h04: mismatch_cnt=1, fault_vector=8'h04, fault stays 0. Two consecutive cycles → fault=1, state_o=3.
- FAULT, fault_clear together with cfg_delay=1 transfer: delay_sel=1, fault/fault_vector/mismatch_cnt=0, WARMUP lasts 5 cycles.
- CNT_W=4 with sustained alternating mismatch and ERR_THRESH=2: mismatch_cnt saturates at 15, never wraps.
- Selftest build: inject_req, cmp_error 2 cycles later → selftest_pass, no fault. No cmp_error within 4 cycles → selftest_fail, fault=1.
